// File: rtl/seq_encoder.sv
// Sparse-activation encoder: forwards nonzero words with their row position
// and emits a per-row occupancy bitmap plus nonzero count.
module seq_encoder #(
   parameter int unsigned SEQ_LEN     = 16,
   parameter int unsigned INDEX_WIDTH = 4,
   parameter int unsigned ACT_WIDTH   = 8,
   parameter int unsigned CNT_WIDTH   = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   in_valid,
   input  logic [ACT_WIDTH-1:0]   in_data,
   output logic                   in_ready,
   output logic                   nz_valid,
   output logic [ACT_WIDTH-1:0]   nz_data,
   output logic [INDEX_WIDTH-1:0] nz_index,
   input  logic                   nz_ready,
   output logic                   seq_valid,
   output logic [SEQ_LEN-1:0]     seq,
   output logic [CNT_WIDTH-1:0]   seq_nnz,
   input  logic                   seq_ready
);

   localparam logic [INDEX_WIDTH-1:0] LAST_POS = INDEX_WIDTH'(SEQ_LEN - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                 state,    state_n;
   logic [INDEX_WIDTH-1:0] pos,      pos_n;
   logic [SEQ_LEN-1:0]     bitmap,   bitmap_n;
   logic [CNT_WIDTH-1:0]   count,    count_n;
   logic                   nz_vld_q, nz_vld_n;
   logic [ACT_WIDTH-1:0]   nz_dat_q, nz_dat_n;
   logic [INDEX_WIDTH-1:0] nz_idx_q, nz_idx_n;
   logic                   accept;

   // Ready depends on the live start and nz_ready inputs, so it is combinational.
   assign in_ready = (state == COLLECT) && !start && (!nz_vld_q || nz_ready);
   assign accept   = in_valid && in_ready;

   assign nz_valid  = nz_vld_q;
   assign nz_data   = nz_dat_q;
   assign nz_index  = nz_idx_q;
   assign seq_valid = (state == DONE);
   assign seq       = bitmap;
   assign seq_nnz   = count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pos      <= '0;
         bitmap   <= '0;
         count    <= '0;
         nz_vld_q <= 1'b0;
         nz_dat_q <= '0;
         nz_idx_q <= '0;
      end else begin
         state    <= state_n;
         pos      <= pos_n;
         bitmap   <= bitmap_n;
         count    <= count_n;
         nz_vld_q <= nz_vld_n;
         nz_dat_q <= nz_dat_n;
         nz_idx_q <= nz_idx_n;
      end
   end

   // Next-state: the nz drain is independent of the row FSM; start overrides all.
   always_comb begin
      state_n  = state;
      pos_n    = pos;
      bitmap_n = bitmap;
      count_n  = count;
      nz_vld_n = nz_vld_q;
      nz_dat_n = nz_dat_q;
      nz_idx_n = nz_idx_q;

      if (nz_vld_q && nz_ready) nz_vld_n = 1'b0;

      if (start) begin
         state_n  = COLLECT;
         pos_n    = '0;
         bitmap_n = '0;
         count_n  = '0;
         nz_vld_n = 1'b0;
      end else begin
         unique case (state)
            IDLE: ;
            COLLECT: begin
               if (accept) begin
                  pos_n = pos + INDEX_WIDTH'(1);
                  if (in_data != '0) begin
                     bitmap_n[pos] = 1'b1;
                     count_n       = count + CNT_WIDTH'(1);
                     nz_vld_n      = 1'b1;
                     nz_dat_n      = in_data;
                     nz_idx_n      = pos;
                  end
                  if (pos == LAST_POS) state_n = DONE;
               end
            end
            DONE: begin
               if (seq_ready) begin
                  state_n  = COLLECT;
                  bitmap_n = '0;
                  count_n  = '0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_encoder.sv
// Directed self-checking bench for seq_encoder with hand-computed expectations.
module tb_seq_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        nz_valid;
   logic [7:0]  nz_data;
   logic [3:0]  nz_index;
   logic        nz_ready;
   logic        seq_valid;
   logic [15:0] seq;
   logic [4:0]  seq_nnz;
   logic        seq_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] row_a [16] = '{8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0,
                              8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9};
   logic [7:0] row_f [16] = '{8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                              8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6};

   seq_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .nz_valid  (nz_valid),
      .nz_data   (nz_data),
      .nz_index  (nz_index),
      .nz_ready  (nz_ready),
      .seq_valid (seq_valid),
      .seq       (seq),
      .seq_nnz   (seq_nnz),
      .seq_ready (seq_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one element; returns 2 time units after the accepting edge.
   task automatic push(input logic [7:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      #1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),  32'd0);
      check({tag, "_nz_valid"},  32'(nz_valid),  32'd0);
      check({tag, "_nz_data"},   32'(nz_data),   32'd0);
      check({tag, "_nz_index"},  32'(nz_index),  32'd0);
      check({tag, "_seq_valid"}, 32'(seq_valid), 32'd0);
      check({tag, "_seq"},       32'(seq),       32'd0);
      check({tag, "_seq_nnz"},   32'(seq_nnz),   32'd0);
   endtask

   initial begin
      logic any_nz;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      nz_ready = 1'b1; seq_ready = 1'b1;
      #3;
      check_all_zero("reset");
      @(posedge clk); #2;
      reset = 1'b0;
      @(posedge clk); #2;
      check("idle_in_ready", 32'(in_ready), 32'd0);

      // Row A: sparse row, free-running downstream
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         push(row_a[i]);
         check("a_nz_valid", 32'(nz_valid), 32'(row_a[i] != 8'd0));
         if (row_a[i] != 8'd0) begin
            check("a_nz_data",  32'(nz_data),  32'(row_a[i]));
            check("a_nz_index", 32'(nz_index), 32'(i));
         end
      end
      check("a_seq_valid", 32'(seq_valid), 32'd1);
      check("a_seq",       32'(seq),       32'h8108);
      check("a_seq_nnz",   32'(seq_nnz),   32'd3);

      // All-zero row, started implicitly after the bitmap handshake
      any_nz = 1'b0;
      for (int i = 0; i < 16; i++) begin
         push(8'd0);
         any_nz = any_nz | nz_valid;
      end
      check("z_no_nz",     32'(any_nz),    32'd0);
      check("z_seq_valid", 32'(seq_valid), 32'd1);
      check("z_seq",       32'(seq),       32'h0000);
      check("z_seq_nnz",   32'(seq_nnz),   32'd0);

      // Dense row 1..16
      for (int i = 0; i < 16; i++) begin
         push(8'(i + 1));
         check("d_nz_valid", 32'(nz_valid), 32'd1);
         check("d_nz_data",  32'(nz_data),  32'(i + 1));
         check("d_nz_index", 32'(nz_index), 32'(i));
      end
      check("d_seq",     32'(seq),     32'hFFFF);
      check("d_seq_nnz", 32'(seq_nnz), 32'd16);

      // Row A again with a 4-cycle nz stall, then a 3-cycle seq stall
      for (int i = 0; i < 4; i++) push(row_a[i]);
      nz_ready = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'd0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("s_in_ready", 32'(in_ready), 32'd0);
         check("s_nz_valid", 32'(nz_valid), 32'd1);
         check("s_nz_data",  32'(nz_data),  32'd5);
         check("s_nz_index", 32'(nz_index), 32'd3);
         @(posedge clk); #2;
      end
      nz_ready = 1'b1;
      for (int i = 4; i < 16; i++) begin
         if (i == 15) seq_ready = 1'b0;
         push(row_a[i]);
         if (i == 8) begin
            check("s_nz7_data",  32'(nz_data),  32'd7);
            check("s_nz7_index", 32'(nz_index), 32'd8);
         end
      end
      in_valid = 1'b1;
      in_data  = 8'd1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("h_seq_valid", 32'(seq_valid), 32'd1);
         check("h_seq",       32'(seq),       32'h8108);
         check("h_seq_nnz",   32'(seq_nnz),   32'd3);
         check("h_in_ready",  32'(in_ready),  32'd0);
         @(posedge clk); #2;
      end
      seq_ready = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
      check("h_seq_dropped", 32'(seq_valid), 32'd0);

      // Next row without start: bitmap must start clean
      for (int i = 0; i < 16; i++) begin
         push((i == 1) ? 8'd3 : 8'd0);
         if (i == 1) begin
            check("n_nz_data",  32'(nz_data),  32'd3);
            check("n_nz_index", 32'(nz_index), 32'd1);
         end
      end
      check("n_seq",     32'(seq),     32'h0002);
      check("n_seq_nnz", 32'(seq_nnz), 32'd1);

      // Abort after 6 accepts with an element offered in the start cycle
      for (int i = 0; i < 6; i++) push((i == 5) ? 8'd2 : 8'd0);
      check("r_nz_pending", 32'(nz_valid), 32'd1);
      nz_ready = 1'b0;
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'd8;
      #1;
      check("r_start_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #2;
      start    = 1'b0;
      in_valid = 1'b0;
      nz_ready = 1'b1;
      check("r_nz_cleared",  32'(nz_valid),  32'd0);
      check("r_seq_valid",   32'(seq_valid), 32'd0);
      for (int i = 0; i < 16; i++) begin
         push(row_f[i]);
         if (row_f[i] != 8'd0) begin
            check("f_nz_data",  32'(nz_data),  32'(row_f[i]));
            check("f_nz_index", 32'(nz_index), 32'(i));
         end
      end
      check("f_seq_valid", 32'(seq_valid), 32'd1);
      check("f_seq",       32'(seq),       32'h8001);
      check("f_seq_nnz",   32'(seq_nnz),   32'd2);

      // Asynchronous reset mid-row with a pending nz word
      push(8'd0);
      push(8'd7);
      nz_ready = 1'b0;
      check("x_nz_pending", 32'(nz_valid), 32'd1);
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      #20;
      reset    = 1'b0;
      nz_ready = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'd5;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #2;
         check("x_idle_in_ready", 32'(in_ready), 32'd0);
         check("x_idle_nz_valid", 32'(nz_valid), 32'd0);
      end
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
